// File: rtl/pipelined_cla_adder.sv
// pipelined_cla_adder: segmented, pipelined carry-lookahead adder/subtractor with valid/ready flow control
module pipelined_cla_adder #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf
);
  localparam int STAGES = WIDTH / SEG;

  logic              adv;
  logic [STAGES-1:0] v_q, c_q, v_i, c_i, c_d;
  logic              o_q, o_d;
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  s_q [STAGES];
  logic [WIDTH-1:0]  a_i [STAGES];
  logic [WIDTH-1:0]  b_i [STAGES];
  logic [WIDTH-1:0]  s_i [STAGES];
  logic [WIDTH-1:0]  s_d [STAGES];
  logic [SEG+1:0]    r;

  // returns {carry out, carry into top bit, segment sum} using flattened lookahead terms
  function automatic logic [SEG+1:0] cla(input logic [SEG-1:0] a, input logic [SEG-1:0] b, input logic ci);
    logic [SEG-1:0] g, p;
    logic [SEG:0]   c;
    logic           t, pp;
    g = a & b;
    p = a ^ b;
    c = '0;
    c[0] = ci;
    for (int j = 0; j < SEG; j++) begin
      t  = g[j];
      pp = p[j];
      for (int m = j - 1; m >= 0; m--) begin
        t  = t | (pp & g[m]);
        pp = pp & p[m];
      end
      c[j+1] = t | (pp & ci);
    end
    return {c[SEG], c[SEG-1], p ^ c[SEG-1:0]};
  endfunction

  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;
  assign out_valid = v_q[STAGES-1];
  assign Sum       = s_q[STAGES-1];
  assign Cout      = c_q[STAGES-1];
  assign Ovf       = o_q;

  // per-stage inputs (entry stage from ports, later stages from skew registers) and segment results
  always_comb begin
    r      = '0;
    c_d    = '0;
    o_d    = 1'b0;
    a_i[0] = A;
    b_i[0] = sub ? ~B : B;
    c_i[0] = sub | Cin;
    s_i[0] = '0;
    v_i[0] = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      a_i[k] = a_q[k-1];
      b_i[k] = b_q[k-1];
      c_i[k] = c_q[k-1];
      s_i[k] = s_q[k-1];
      v_i[k] = v_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      r                     = cla(a_i[k][k*SEG +: SEG], b_i[k][k*SEG +: SEG], c_i[k]);
      s_d[k]                = s_i[k];
      s_d[k][k*SEG +: SEG]  = r[SEG-1:0];
      c_d[k]                = r[SEG+1];
      if (k == STAGES - 1) o_d = r[SEG+1] ^ r[SEG];
    end
  end

  // whole pipeline advances together; everything holds while the output is stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      c_q <= '0;
      o_q <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else if (adv) begin
      v_q <= v_i;
      c_q <= c_d;
      o_q <= o_d;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= a_i[k];
        b_q[k] <= b_i[k];
        s_q[k] <= s_d[k];
      end
    end
  end
endmodule

// File: tb/tb_pipelined_cla_adder.sv
// tb_pipelined_cla_adder: scoreboard bench over three WIDTH/SEG configurations
module tb_pipelined_cla_adder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : lane
    localparam int W   = (g == 0) ? 16 : (g == 1) ? 8 : 32;
    localparam int S   = (g == 0) ? 4 : 8;
    localparam int STG = W / S;

    typedef struct packed {
      logic [W-1:0] sm;
      logic         co;
      logic         ov;
      logic         lat;
      int           acc;
    } exp_t;

    logic         rst_n = 1'b0, in_valid = 1'b0, cin = 1'b0, sub = 1'b0, out_ready = 1'b1, rnd = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic         in_ready, out_valid, cout, ovf;
    logic [W-1:0] sum;
    logic         fin = 1'b0;
    logic         held_v = 1'b0;
    logic [W+1:0] held = '0;
    int           stall_at = -100;
    exp_t         q[$];
    exp_t         e;

    pipelined_cla_adder #(.WIDTH(W), .SEG(S)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .A(a), .B(b), .Cin(cin), .sub(sub),
      .out_valid(out_valid), .out_ready(out_ready),
      .Sum(sum), .Cout(cout), .Ovf(ovf)
    );

    // reference: unsigned arithmetic for Sum/Cout, signed range test for Ovf
    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci, input logic s);
      logic [W:0] full;
      longint     res, lim;
      full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
      res  = s ? longint'($signed(x)) - longint'($signed(y))
               : longint'($signed(x)) + longint'($signed(y)) + longint'(ci);
      lim  = longint'(1) << (W - 1);
      return {s ? x - y : full[W-1:0], s ? x >= y : full[W], res >= lim || res < -lim};
    endfunction

    task automatic tick();
      @(posedge clk);
      #1;
      out_ready = rnd ? ($urandom_range(0, 3) != 0) : !(cyc >= stall_at && cyc < stall_at + 4);
    endtask

    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci, input logic s,
                         input logic [W+1:0] ex, input logic lat);
      in_valid = 1'b1;
      a = x;
      b = y;
      cin = ci;
      sub = s;
      for (int n = 0; n < 200; n++) begin
        @(negedge clk);
        if (in_ready) begin
          q.push_back('{sm: ex[W+1:2], co: ex[1], ov: ex[0], lat: lat, acc: cyc});
          tick();
          in_valid = 1'b0;
          return;
        end
        tick();
      end
      errors++;
      $display("FAIL issue_timeout lane=%0d in_ready=0 required=1", g);
      in_valid = 1'b0;
    endtask

    task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_sum", sum, 0);
      chk("rst_cout", cout, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_in_ready", in_ready, 1);
      q.delete();
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
    endtask

    task automatic drain();
      rnd = 1'b0;
      stall_at = -100;
      for (int n = 0; n < 100 && q.size() > 0; n++) tick();
      if (q.size() != 0) begin
        errors++;
        $display("FAIL drain lane=%0d pending=%0d required=0", g, q.size());
      end
    endtask

    task automatic rand_op(input logic lat);
      logic [W-1:0] x, y;
      logic         ci, s;
      x  = W'($urandom);
      y  = W'($urandom);
      ci = 1'($urandom);
      s  = 1'($urandom);
      issue(x, y, ci, s, model(x, y, ci, s), lat);
    endtask

    // monitor: pops the scoreboard on every delivered result and watches stalls
    always @(negedge clk) begin
      if (!rst_n) held_v = 1'b0;
      else begin
        if (held_v) chk("stall_hold", {out_valid, sum, cout, ovf}, {1'b1, held});
        if (out_valid && !out_ready) begin
          chk("stall_in_ready", in_ready, 0);
          held_v = 1'b1;
          held   = {sum, cout, ovf};
        end else held_v = 1'b0;
        if (out_valid && out_ready) begin
          if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_result lane=%0d sum=%0h required=none", g, sum);
          end else begin
            e = q.pop_front();
            chk("sum", sum, e.sm);
            chk("cout", cout, e.co);
            chk("ovf", ovf, e.ov);
            if (e.lat) chk("latency", cyc - e.acc, STG);
          end
        end
      end
    end

    initial begin
      logic [W-1:0] ones, maxp, minn;
      ones = '1;
      maxp = ones >> 1;
      minn = ~maxp;
      do_reset();
      for (int i = 0; i < 5; i++) begin
        tick();
        chk("idle_out_valid", out_valid, 0);
      end
      issue(W'(7), W'(15), 1'b0, 1'b0, {W'(22), 2'b00}, 1'b1);
      issue(ones, W'(0), 1'b1, 1'b0, {W'(0), 2'b10}, 1'b1);
      issue(maxp, W'(1), 1'b0, 1'b0, {minn, 2'b01}, 1'b1);
      issue(W'(5), W'(7), 1'b1, 1'b1, {ones - W'(1), 2'b00}, 1'b1);
      issue(minn, W'(1), 1'b0, 1'b1, {maxp, 2'b11}, 1'b1);
      drain();
      stall_at = cyc + 6;
      for (int i = 0; i < 8; i++) rand_op(1'b0);
      drain();
      for (int i = 0; i < 3; i++) rand_op(1'b0);
      do_reset();
      for (int i = 0; i < 6; i++) begin
        tick();
        chk("post_reset_idle", out_valid, 0);
      end
      rand_op(1'b1);
      drain();
      rnd = 1'b1;
      for (int i = 0; i < 3334; i++) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, 2)) tick();
        rand_op(1'b0);
      end
      drain();
      fin = 1'b1;
    end
  end

  initial begin
    for (int n = 0; n < 60000 && !(lane[0].fin && lane[1].fin && lane[2].fin); n++) @(posedge clk);
    if (!(lane[0].fin && lane[1].fin && lane[2].fin)) begin
      errors++;
      $display("FAIL timeout lanes_done=0 required=1");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
